clk_prog_ctrl: RTL and testbench
================================

CLK_PROG_CTRL -- requirements
Module: clk_prog_ctrl

Interface
REQ-001 SHALL have parameter PROG_TIMEOUT, default 4096, meaning the maximum CLK cycles spent in WAIT_DONE before an error is flagged.
REQ-002 SHALL have parameter PLL_RST_CYCLES, default 16, meaning the width of the pll_reset pulse in CLK cycles.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 256, meaning the CLK cycles waited after pll_reset deasserts before completion.
REQ-004 CLK  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  programming request present.
REQ-007 req_ready  output  1  high only in IDLE; a request is accepted when req_valid&req_ready.
REQ-008 req_sel  input  2  index of the programmable clock to program.
REQ-009 req_m  input  8  multiplier minus one (M-1), legal 1..255.
REQ-010 req_d  input  8  divider minus one (D-1), legal 0..255.
REQ-011 progen  output  4  one-hot per-clock program enable; only bit req_sel is ever driven high.
REQ-012 progdata  output  1  serial program data.
REQ-013 progclk  output  1  program clock, CLK/2.
REQ-014 progdone_inv  input  1  high while any programmable clock has not finished programming.
REQ-015 pll_reset  output  1  reset to the downstream PLLs.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse on successful completion.
REQ-018 error  output  1  one-cycle pulse on rejected request or timeout.

Function
REQ-019 SHALL latch req_sel, req_m and req_d on acceptance; later changes of these inputs SHALL have no effect on the operation in progress.
REQ-020 SHALL reject a request with req_m==0 by pulsing error for one cycle in the cycle after acceptance and staying in IDLE, with no progen activity.
REQ-021 progclk SHALL toggle every CLK cycle while busy and SHALL be held low in IDLE.
REQ-022 One bit slot SHALL be 2 CLK cycles (progclk low, then high); progen and progdata SHALL change only at the start of a slot, i.e. while progclk is low.
REQ-023 SHALL implement the states IDLE -> LOAD_D -> GAP1 -> LOAD_M -> GAP2 -> GO -> WAIT_DONE -> PLL_RST -> SETTLE -> DONE -> IDLE.
REQ-024 LOAD_D SHALL drive 10 slots with progen[sel]=1: progdata = 1, 0, then req_d bits 0..7 (LSB first).
REQ-025 LOAD_M SHALL drive 10 slots with progen[sel]=1: progdata = 1, 1, then req_m bits 0..7 (LSB first).
REQ-026 GAP1 and GAP2 SHALL each last 1 slot with progen=0 and progdata=0.
REQ-027 GO SHALL last 1 slot with progen[sel]=1 and progdata=0.
REQ-028 WAIT_DONE SHALL hold progen=0 for a minimum of 4 slots, then SHALL exit to PLL_RST on the first CLK cycle in which progdone_inv==0.
REQ-029 If progdone_inv remains high for PROG_TIMEOUT cycles in WAIT_DONE, the block SHALL pulse error and return to IDLE without asserting pll_reset.
REQ-030 PLL_RST SHALL assert pll_reset for exactly PLL_RST_CYCLES cycles.
REQ-031 SETTLE SHALL wait SETTLE_CYCLES cycles with pll_reset=0.
REQ-032 DONE SHALL last one cycle, pulse done, then return to IDLE.
REQ-033 req_valid while busy SHALL be ignored (req_ready=0); no request queuing.
REQ-034 done and error SHALL never both be high in the same cycle.
REQ-035 All outputs SHALL be registered.

Reset
REQ-036 reset SHALL take priority over all events, including during LOAD_*/WAIT_DONE.
REQ-037 Reset values: state=IDLE, progen=0, progdata=0, progclk=0, pll_reset=0, busy=0, done=0, error=0, req_ready=1 in the cycle after reset deasserts; all counters cleared.
REQ-038 Reset mid-programming SHALL abandon the sequence with no done pulse; the partially loaded DCM is recovered by the next full request.

Verification
REQ-039 sel=1, m=0x0A, d=0x01, progdone_inv low 10 cycles after GO -> progen=4'b0010 only; LOAD_D stream 1,0,1,0,0,0,0,0,0,0; LOAD_M stream 1,1,0,1,0,1,0,0,0,0; pll_reset high 16 cycles; done pulses once; busy falls the cycle after done.
REQ-040 sel=0, m=0x00 -> error pulse 1 cycle after acceptance, progen stays 0, req_ready stays 1.
REQ-041 progdone_inv held high -> error pulses exactly PROG_TIMEOUT cycles after WAIT_DONE entry; pll_reset never asserted; next request is accepted.
REQ-042 reset asserted in the 5th slot of LOAD_M -> next cycle all outputs at their reset values; a subsequent request completes normally.
REQ-043 req_valid held high through a full operation with changing req_m -> exactly one operation per IDLE acceptance; the streamed M equals the value latched at acceptance.
REQ-044 progdone_inv low throughout -> WAIT_DONE still lasts exactly 4 slots (8 cycles) before PLL_RST.

Source files
------------

// File: rtl/clk_prog_ctrl.sv
// Serial programming sequencer for up to four programmable clock synthesizers:
// streams D then M over progen/progdata/progclk, waits for lock, pulses the PLL reset.
module clk_prog_ctrl #(
    parameter int PROG_TIMEOUT   = 4096,
    parameter int PLL_RST_CYCLES = 16,
    parameter int SETTLE_CYCLES  = 256
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_sel,
    input  logic [7:0] req_m,
    input  logic [7:0] req_d,
    output logic [3:0] progen,
    output logic       progdata,
    output logic       progclk,
    input  logic       progdone_inv,
    output logic       pll_reset,
    output logic       busy,
    output logic       done,
    output logic       error
);
    localparam int MAX_A = (PROG_TIMEOUT > SETTLE_CYCLES) ? PROG_TIMEOUT : SETTLE_CYCLES;
    localparam int MAX_B = (MAX_A > PLL_RST_CYCLES) ? MAX_A : PLL_RST_CYCLES;
    localparam int MAXC  = (MAX_B > 8) ? MAX_B : 8;
    localparam int CW    = $clog2(MAXC + 1);

    localparam logic [CW-1:0] TO_LAST     = CW'(PROG_TIMEOUT - 1);
    localparam logic [CW-1:0] RST_LAST    = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] WAIT_MIN    = CW'(7);

    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] LOAD_D    = 4'd1;
    localparam logic [3:0] GAP1      = 4'd2;
    localparam logic [3:0] LOAD_M    = 4'd3;
    localparam logic [3:0] GAP2      = 4'd4;
    localparam logic [3:0] GO        = 4'd5;
    localparam logic [3:0] WAIT_DONE = 4'd6;
    localparam logic [3:0] PLL_RST   = 4'd7;
    localparam logic [3:0] SETTLE    = 4'd8;
    localparam logic [3:0] DONE      = 4'd9;

    logic [3:0]    state;
    logic [3:0]    slot;
    logic [CW-1:0] cnt;
    logic [1:0]    sel_q;
    logic [7:0]    m_q;
    logic [7:0]    d_q;

    function automatic logic [3:0] onehot(input logic [1:0] s);
        return 4'b0001 << s;
    endfunction

    // Load frame: two header bits (1, second) then the value LSB first.
    function automatic logic slot_bit(input logic second, input logic [7:0] v, input logic [3:0] s);
        logic [3:0] idx;
        idx = s - 4'd2;
        if (s == 4'd0) return 1'b1;
        if (s == 4'd1) return second;
        return v[idx[2:0]];
    endfunction

    always_ff @(posedge CLK) begin
        if (reset) begin
            state     <= IDLE;
            slot      <= '0;
            cnt       <= '0;
            sel_q     <= '0;
            m_q       <= '0;
            d_q       <= '0;
            progen    <= '0;
            progdata  <= 1'b0;
            progclk   <= 1'b0;
            pll_reset <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            done    <= 1'b0;
            error   <= 1'b0;
            progclk <= ~progclk;
            case (state)
                IDLE: begin
                    progclk   <= 1'b0;
                    progen    <= '0;
                    progdata  <= 1'b0;
                    pll_reset <= 1'b0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                    cnt       <= '0;
                    slot      <= '0;
                    if (req_valid && req_ready) begin
                        if (req_m == 8'd0) begin
                            error <= 1'b1;
                        end else begin
                            sel_q     <= req_sel;
                            m_q       <= req_m;
                            d_q       <= req_d;
                            state     <= LOAD_D;
                            busy      <= 1'b1;
                            req_ready <= 1'b0;
                            progen    <= onehot(req_sel);
                            progdata  <= 1'b1;
                        end
                    end
                end
                // progclk high now means the next edge opens a new slot.
                LOAD_D: if (progclk) begin
                    if (slot == 4'd9) begin
                        state    <= GAP1;
                        progen   <= '0;
                        progdata <= 1'b0;
                    end else begin
                        slot     <= slot + 4'd1;
                        progdata <= slot_bit(1'b0, d_q, slot + 4'd1);
                    end
                end
                GAP1: if (progclk) begin
                    state    <= LOAD_M;
                    slot     <= '0;
                    progen   <= onehot(sel_q);
                    progdata <= 1'b1;
                end
                LOAD_M: if (progclk) begin
                    if (slot == 4'd9) begin
                        state    <= GAP2;
                        progen   <= '0;
                        progdata <= 1'b0;
                    end else begin
                        slot     <= slot + 4'd1;
                        progdata <= slot_bit(1'b1, m_q, slot + 4'd1);
                    end
                end
                GAP2: if (progclk) begin
                    state    <= GO;
                    progen   <= onehot(sel_q);
                    progdata <= 1'b0;
                end
                GO: if (progclk) begin
                    state  <= WAIT_DONE;
                    progen <= '0;
                    cnt    <= '0;
                end
                WAIT_DONE: begin
                    cnt <= cnt + 1'b1;
                    if (cnt >= WAIT_MIN && !progdone_inv) begin
                        state     <= PLL_RST;
                        pll_reset <= 1'b1;
                        cnt       <= '0;
                    end else if (cnt == TO_LAST) begin
                        state     <= IDLE;
                        error     <= 1'b1;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        progclk   <= 1'b0;
                    end
                end
                PLL_RST: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == RST_LAST) begin
                        state     <= SETTLE;
                        pll_reset <= 1'b0;
                        cnt       <= '0;
                    end
                end
                SETTLE: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == SETTLE_LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                    progclk   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_clk_prog_ctrl.sv
// Scoreboarded bench: expected load-frame slots are queued per request and checked
// by a monitor; per-scenario tasks check timing of pll_reset, done, error and busy.
module tb_clk_prog_ctrl;
    localparam int TO     = 64;
    localparam int RSTC   = 16;
    localparam int SETTLE = 20;
    localparam int WAIT_ENTRY = 46;   // 23 slots of load/gap/go after acceptance

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_sel = '0;
    logic [7:0] req_m = '0;
    logic [7:0] req_d = '0;
    logic [3:0] progen;
    logic       progdata, progclk, pll_reset, busy, done, error;
    logic       progdone_inv = 1'b1;

    int vectors = 0;
    int miscompares = 0;
    logic [4:0] sb[$];

    clk_prog_ctrl #(.PROG_TIMEOUT(TO), .PLL_RST_CYCLES(RSTC), .SETTLE_CYCLES(SETTLE)) dut (
        .CLK(CLK), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_sel(req_sel), .req_m(req_m), .req_d(req_d), .progen(progen),
        .progdata(progdata), .progclk(progclk), .progdone_inv(progdone_inv),
        .pll_reset(pll_reset), .busy(busy), .done(done), .error(error));

    always #5 CLK = ~CLK;

    // One sample per driven slot, taken in the progclk-high half.
    always @(negedge CLK) begin
        if (!reset) begin
            if (done && error) begin
                miscompares++;
                $display("FAIL done_error_overlap: done=%b error=%b, required not both", done, error);
            end
            if (progclk && progen != 4'd0) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL slot_unexpected: got progen=%b data=%b, required no slot", progen, progdata);
                end else begin
                    logic [4:0] exp;
                    exp = sb.pop_front();
                    if ({progen, progdata} !== exp) begin
                        miscompares++;
                        $display("FAIL slot_stream: got %b, required %b", {progen, progdata}, exp);
                    end
                end
            end
        end
    end

    task automatic push_op(input logic [1:0] sel, input logic [7:0] m, input logic [7:0] d);
        logic [3:0] oh;
        oh = 4'b0001 << sel;
        sb.push_back({oh, 1'b1}); sb.push_back({oh, 1'b0});
        for (int i = 0; i < 8; i++) sb.push_back({oh, d[i]});
        sb.push_back({oh, 1'b1}); sb.push_back({oh, 1'b1});
        for (int i = 0; i < 8; i++) sb.push_back({oh, m[i]});
        sb.push_back({oh, 1'b0});
    endtask

    // drop_k: cycle (0 = first LOAD_D cycle) at which progdone_inv falls; <0 = low throughout.
    task automatic run_op(input logic [1:0] sel, input logic [7:0] m, input logic [7:0] d,
                          input int drop_k, input bit timeout, input bit hold);
        int k, pll_k, pll_cnt, done_k, done_cnt, err_k, bad, exp_pll;
        logic [3:0] oh;
        oh = 4'b0001 << sel;
        pll_k = -1; pll_cnt = 0; done_k = -1; done_cnt = 0; err_k = -1; bad = 0;
        push_op(sel, m, d);
        @(negedge CLK);
        req_valid = 1'b1; req_sel = sel; req_m = m; req_d = d;
        progdone_inv = (drop_k < 0) ? 1'b0 : 1'b1;
        @(negedge CLK);
        if (!hold) req_valid = 1'b0;
        req_m = ~m | 8'd1; req_d = ~d; req_sel = sel + 2'd1;
        for (k = 0; k < 600; k++) begin
            if (pll_reset) begin
                if (pll_k < 0) pll_k = k;
                pll_cnt++;
            end
            if (done) begin done_cnt++; done_k = k; end
            if (error) err_k = k;
            if (busy && progclk !== k[0]) bad++;
            if (progen != 4'd0 && progen != oh) bad++;
            if (!busy) break;
            if (hold) req_m = 8'($urandom_range(1, 255));
            if (drop_k >= 0 && k == drop_k) progdone_inv = 1'b0;
            @(negedge CLK);
        end
        req_valid = 1'b0;
        vectors++;
        if (k >= 600) begin
            miscompares++;
            $display("FAIL op_timeout: busy still high after %0d cycles, required to finish", k);
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL progclk_progen: %0d bad cycles, required 0", bad);
        end
        vectors++;
        if (sb.size() !== 0) begin
            miscompares++;
            $display("FAIL sb_leftover: %0d slots not seen, required 0", sb.size());
            sb.delete();
        end
        if (timeout) begin
            vectors++;
            if (err_k !== WAIT_ENTRY + TO || pll_cnt !== 0 || done_cnt !== 0) begin
                miscompares++;
                $display("FAIL timeout_err: err_k=%0d pll=%0d done=%0d, required %0d 0 0",
                         err_k, pll_cnt, done_cnt, WAIT_ENTRY + TO);
            end
        end else begin
            exp_pll = ((drop_k > WAIT_ENTRY + 7) ? drop_k : WAIT_ENTRY + 7) + 1;
            vectors++;
            if (pll_k !== exp_pll || pll_cnt !== RSTC) begin
                miscompares++;
                $display("FAIL pll_reset: start=%0d width=%0d, required %0d %0d", pll_k, pll_cnt, exp_pll, RSTC);
            end
            vectors++;
            if (done_cnt !== 1 || done_k !== exp_pll + RSTC + SETTLE || k !== done_k + 1 || err_k !== -1) begin
                miscompares++;
                $display("FAIL done_pulse: cnt=%0d at=%0d busy_fall=%0d err_k=%0d, required 1 %0d %0d -1",
                         done_cnt, done_k, k, err_k, exp_pll + RSTC + SETTLE, exp_pll + RSTC + SETTLE + 1);
            end
        end
        progdone_inv = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        vectors++;
        if ({progen, progdata, progclk, pll_reset, busy, done, error, req_ready} !== 11'b0000_0000001) begin
            miscompares++;
            $display("FAIL reset_values: got %b, required 00000000001",
                     {progen, progdata, progclk, pll_reset, busy, done, error, req_ready});
        end
    endtask

    task automatic test_basic;
        run_op(2'd1, 8'h0A, 8'h01, WAIT_ENTRY + 9, 1'b0, 1'b0);
    endtask

    task automatic test_reject;
        @(negedge CLK);
        req_valid = 1'b1; req_sel = 2'd0; req_m = 8'h00; req_d = 8'h33;
        @(negedge CLK);
        req_valid = 1'b0;
        vectors++;
        if ({error, req_ready, busy, progen} !== 7'b1100000) begin
            miscompares++;
            $display("FAIL reject_pulse: got %b, required 1100000", {error, req_ready, busy, progen});
        end
        @(negedge CLK);
        vectors++;
        if ({error, req_ready, busy, progen} !== 7'b0100000) begin
            miscompares++;
            $display("FAIL reject_after: got %b, required 0100000", {error, req_ready, busy, progen});
        end
    endtask

    task automatic test_timeout;
        run_op(2'd2, 8'h55, 8'hAA, 100000, 1'b1, 1'b0);
        run_op(2'd3, 8'h12, 8'h34, WAIT_ENTRY + 20, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid;
        push_op(2'd1, 8'hC3, 8'h3C);
        @(negedge CLK);
        req_valid = 1'b1; req_sel = 2'd1; req_m = 8'hC3; req_d = 8'h3C;
        @(negedge CLK);
        req_valid = 1'b0;
        repeat (30) @(negedge CLK);   // now at first cycle of the 5th LOAD_M slot
        reset = 1'b1;
        @(negedge CLK);
        vectors++;
        if ({progen, progdata, progclk, pll_reset, busy, done, error, req_ready} !== 11'b0000_0000001) begin
            miscompares++;
            $display("FAIL reset_mid: got %b, required 00000000001",
                     {progen, progdata, progclk, pll_reset, busy, done, error, req_ready});
        end
        vectors++;
        if (sb.size() !== 7) begin
            miscompares++;
            $display("FAIL reset_mid_slots: %0d left, required 7", sb.size());
        end
        sb.delete();
        reset = 1'b0;
        run_op(2'd0, 8'hFF, 8'h00, WAIT_ENTRY + 30, 1'b0, 1'b0);
    endtask

    task automatic test_fast_done;
        run_op(2'd3, 8'h01, 8'hFF, -1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        run_op(2'd2, 8'h81, 8'h7E, -1, 1'b0, 1'b1);
        run_op(2'd1, 8'h5A, 8'hC0, WAIT_ENTRY + 12, 1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reject();
        test_timeout();
        test_reset_mid();
        test_fast_done();
        test_back_to_back();
        repeat (4) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
